// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants and encodings for the wide add/subtract sequencer.
package wide_add_sequencer_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/wide_add_sequencer_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups joined by a lookahead carry unit.
module CLA_16bit_LCU (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] p;
   logic [15:0] g;
   logic [15:0] c;
   logic [3:0]  gp;
   logic [3:0]  gg;
   logic [4:0]  gc;

   // Bit and group propagate/generate, group carries, then bit carries and sum.
   always_comb begin
      p  = A ^ B;
      g  = A & B;
      gp = '0;
      gg = '0;
      gc = '0;
      c  = '0;
      for (int k = 0; k < 4; k++) begin
         gp[k] = &p[4*k +: 4];
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end
      gc[0] = cin;
      gc[1] = gg[0] | (gp[0] & cin);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & cin);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
      sum  = p ^ c;
      cout = gc[4];
   end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle NWORDS*16-bit add/subtract built on one shared 16-bit CLA,
// one slice per clock, LSW first, carry chained through carry_q.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; outputs hold the last result
//   ST_RUN  | computing slice idx_q each cycle (busy=1)
//   ST_DONE | one-cycle done pulse; a start here is accepted as in IDLE
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter int NWORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      op_sub,
   input  logic [SLICE_W*NWORDS-1:0] a,
   input  logic [SLICE_W*NWORDS-1:0] b,
   output logic                      busy,
   output logic                      done,
   output logic [SLICE_W*NWORDS-1:0] result,
   output logic                      cout,
   output logic                      overflow,
   output logic                      zero
);

   localparam int W  = SLICE_W * NWORDS;
   localparam int IW = $clog2(NWORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

   state_t            state_q;
   state_t            state_d;
   logic [W-1:0]      a_q;
   logic [W-1:0]      b_q;
   logic              sub_q;
   logic [IW-1:0]     idx_q;
   logic              carry_q;

   logic [SLICE_W-1:0] add_a;
   logic [SLICE_W-1:0] add_b;
   logic [SLICE_W-1:0] add_sum;
   logic               add_cin;
   logic               add_cout;
   logic               sub_en;
   logic               accept;
   logic               last_slice;

   assign sub_en     = (sub_q == OP_SUB);
   assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign last_slice = (state_q == ST_RUN) && (idx_q == LAST_IDX);

   assign add_a   = a_q[SLICE_W*idx_q +: SLICE_W];
   assign add_b   = b_q[SLICE_W*idx_q +: SLICE_W] ^ {SLICE_W{sub_en}};
   assign add_cin = (idx_q == '0) ? sub_en : carry_q;

   CLA_16bit_LCU u_cla (
      .A    (add_a),
      .B    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_RUN;
         ST_RUN:  if (last_slice) state_d = ST_DONE;
         ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture, slice write-back and final flag update.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= OP_ADD;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         sub_q   <= op_sub;
         idx_q   <= '0;
         carry_q <= 1'b0;
         result  <= '0;
      end else if (state_q == ST_RUN) begin
         result[SLICE_W*idx_q +: SLICE_W] <= add_sum;
         carry_q <= add_cout;
         idx_q   <= idx_q + 1'b1;
         if (last_slice) begin
            cout     <= add_cout;
            // b' MSB is the (possibly inverted) B bit fed to the adder.
            overflow <= (a_q[W-1] == (b_q[W-1] ^ sub_en))
                        && (add_sum[SLICE_W-1] != a_q[W-1]);
            // Lower words were written on earlier RUN edges; result was
            // cleared at start, so this covers the whole word.
            zero     <= (result[W-SLICE_W-1:0] == '0) && (add_sum == '0);
         end
      end
   end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (NWORDS=4) with a result scoreboard.
module tb_wide_add_sequencer;

   localparam int NW = 4;
   localparam int W  = 16 * NW;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         zero;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t last_exp;

   always #5 clk = ~clk;

   wide_add_sequencer #(.NWORDS(NW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero)
   );

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic s);
      exp_t         m;
      logic [W-1:0] yy;
      logic [W:0]   t;
      yy  = s ? ~y : y;
      t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
      m.r = t[W-1:0];
      m.c = t[W];
      m.v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      m.z = (t[W-1:0] == '0);
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive start in the current cycle, follow the op to its done pulse and
   // compare against the scoreboard. Optionally fire an extra start mid-RUN.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input bit inject);
      exp_t e;
      a      = x;
      b      = y;
      op_sub = s;
      start  = 1'b1;
      sb.push_back(model(x, y, s));
      tick();
      start  = 1'b0;
      a      = {$urandom, $urandom};
      b      = {$urandom, $urandom};
      op_sub = ~s;
      for (int i = 0; i < NW; i++) begin
         chk1("busy_run", busy, 1'b1);
         chk1("done_early", done, 1'b0);
         if (inject && i == 1) start = 1'b1;
         tick();
         start = 1'b0;
      end
      chk1("done_pulse", done, 1'b1);
      chk1("busy_at_done", busy, 1'b0);
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL sb_empty observed=0 expected=1");
      end
      if (sb.size() != 0) begin
         e        = sb.pop_front();
         last_exp = e;
         chkw("result", result, e.r);
         chk1("cout", cout, e.c);
         chk1("overflow", overflow, e.v);
         chk1("zero", zero, e.z);
      end
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      tick();
      tick();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chkw("rst_result", result, '0);
      chk1("rst_cout", cout, 1'b0);
      chk1("rst_overflow", overflow, 1'b0);
      chk1("rst_zero", zero, 1'b0);
      rst = 1'b0;
      tick();

      // Carry chaining across the first slice boundary.
      do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
      chkw("chain_const", result, 64'h0000_0000_0001_0000);
      tick();
      chk1("done_one_cycle", done, 1'b0);

      // Full wrap to zero.
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      chk1("wrap_zero_const", zero, 1'b1);
      chk1("wrap_cout_const", cout, 1'b1);
      tick();

      // Subtract, then a back-to-back start issued in the DONE cycle.
      do_op(64'd5, 64'd3, 1'b1, 1'b0);
      chkw("sub_const", result, 64'd2);
      do_op(64'd0, 64'd1, 1'b1, 1'b0);
      chkw("borrow_const", result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk1("borrow_cout_const", cout, 1'b0);
      tick();

      // Signed overflow both directions.
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      chk1("ovf_add_const", overflow, 1'b1);
      tick();
      do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
      chk1("ovf_sub_const", overflow, 1'b1);
      tick();

      // start during RUN is ignored and never executed later.
      do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk1("ignored_no_done", done, 1'b0);
         chk1("ignored_no_busy", busy, 1'b0);
      end
      chkw("ignored_result_held", result, last_exp.r);

      // Reset on the 2nd RUN cycle aborts the op.
      a      = 64'hAAAA_5555_AAAA_5555;
      b      = 64'h1111_2222_3333_4444;
      op_sub = 1'b0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      rst    = 1'b1;
      tick();
      rst    = 1'b0;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", done, 1'b0);
      chkw("abort_result", result, '0);
      chk1("abort_cout", cout, 1'b0);
      chk1("abort_overflow", overflow, 1'b0);
      chk1("abort_zero", zero, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk1("abort_no_done", done, 1'b0);
      end
      do_op(64'd3245, 64'd16785, 1'b0, 1'b0);
      chkw("post_abort_const", result, 64'd20030);
      tick();

      // A few random operations.
      for (int i = 0; i < 6; i++) begin
         do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
         tick();
      end

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
